// File: rtl/pipe_hazard_if.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_if
// Brief    : D-stage decode fields, memory handshake and pipeline control
//            bundle shared between the datapath and pipe_hazard_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
interface pipe_hazard_if;
  logic [4:0] drs;
  logic [4:0] drt;
  logic       d_use_rs;
  logic       d_use_rt;
  logic [4:0] drn;
  logic       dwreg;
  logic       dm2reg;
  logic       dwmem;
  logic       d_branch_taken;
  logic       mem_ack;
  logic [1:0] fwda;
  logic [1:0] fwdb;
  logic       wpcir;
  logic       bubble;
  logic       adv;
  logic       flush_fd;
  logic       mem_req;
  logic       mem_err;

  // Datapath side: supplies decode fields and memory ack, consumes controls
  modport master (
    output drs, drt, d_use_rs, d_use_rt, drn, dwreg, dm2reg, dwmem,
           d_branch_taken, mem_ack,
    input  fwda, fwdb, wpcir, bubble, adv, flush_fd, mem_req, mem_err
  );

  // Controller side
  modport slave (
    input  drs, drt, d_use_rs, d_use_rt, drn, dwreg, dm2reg, dwmem,
           d_branch_taken, mem_ack,
    output fwda, fwdb, wpcir, bubble, adv, flush_fd, mem_req, mem_err
  );
endinterface
`default_nettype wire

// File: rtl/pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : pipe_hazard_ctrl
// Brief    : Hazard/sequencing controller for the 5-stage pipeline: operand
//            forwarding, load-use stall, branch flush and a memory-wait FSM
//            that freezes the pipeline while a slow data memory completes.
// Revision : 1.0 - initial release
// ============================================================================
module pipe_hazard_ctrl #(
  parameter int DELAY_SLOT  = 1,
  parameter int MEM_TIMEOUT = 255
) (
  input wire           clk,
  input wire           clrn,
  pipe_hazard_if.slave hz
);

  localparam logic [1:0] c_IDLE    = 2'd0;
  localparam logic [1:0] c_WAIT    = 2'd1;
  localparam logic [1:0] c_DONE    = 2'd2;
  localparam logic [7:0] c_TIMEOUT = 8'(MEM_TIMEOUT);
  localparam logic       c_FLUSH   = (DELAY_SLOT == 0);

  // E and M stage shadows of destination and write-back controls
  logic [4:0] r_ern, r_mrn;
  logic       r_ewreg, r_em2reg, r_ewmem;
  logic       r_mwreg, r_mm2reg, r_mwmem;

  logic [1:0] r_state;
  logic [7:0] r_cnt;
  logic       r_err;

  logic       w_memop, w_freeze, w_stall;
  logic       w_adv, w_wpcir, w_bubble, w_flush;
  logic [1:0] w_fwda, w_fwdb;

  // E wins over M; an E-stage load has no data yet so it cannot forward
  function automatic logic [1:0] fwd_sel(
    input logic [4:0] src,
    input logic [4:0] ern, input logic ewreg, input logic em2reg,
    input logic [4:0] mrn, input logic mwreg, input logic mm2reg
  );
    logic [1:0] sel;
    sel = 2'd0;
    if (ewreg && ern != 5'd0 && ern == src && !em2reg)
      sel = 2'd1;
    else if (mwreg && mm2reg && mrn != 5'd0 && mrn == src)
      sel = 2'd3;
    else if (mwreg && mrn != 5'd0 && mrn == src)
      sel = 2'd2;
    return sel;
  endfunction

  // Forwarding selects, load-use detection and memory freeze
  always_comb begin
    w_fwda   = fwd_sel(hz.drs, r_ern, r_ewreg, r_em2reg, r_mrn, r_mwreg, r_mm2reg);
    w_fwdb   = fwd_sel(hz.drt, r_ern, r_ewreg, r_em2reg, r_mrn, r_mwreg, r_mm2reg);
    w_memop  = r_mm2reg || r_mwmem;
    w_freeze = ((r_state == c_IDLE) && w_memop) || (r_state == c_WAIT);
    w_stall  = r_ewreg && r_em2reg && (r_ern != 5'd0) &&
               ((hz.d_use_rs && r_ern == hz.drs) || (hz.d_use_rt && r_ern == hz.drt));
  end

  // Pipeline control priority: freeze over load-use stall over normal flow
  always_comb begin
    w_adv    = 1'b1;
    w_wpcir  = 1'b1;
    w_bubble = 1'b0;
    w_flush  = 1'b0;
    if (w_freeze) begin
      w_adv   = 1'b0;
      w_wpcir = 1'b0;
    end else if (w_stall) begin
      w_wpcir  = 1'b0;
      w_bubble = 1'b1;
    end else begin
      w_flush = hz.d_branch_taken && c_FLUSH;
    end
  end

  assign hz.fwda     = w_fwda;
  assign hz.fwdb     = w_fwdb;
  assign hz.adv      = w_adv;
  assign hz.wpcir    = w_wpcir;
  assign hz.bubble   = w_bubble;
  assign hz.flush_fd = w_flush;
  assign hz.mem_req  = w_freeze;
  assign hz.mem_err  = r_err;

  // Shadow pipeline advances with the real ID/EX and EX/MEM registers
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_ern    <= 5'd0;
      r_ewreg  <= 1'b0;
      r_em2reg <= 1'b0;
      r_ewmem  <= 1'b0;
      r_mrn    <= 5'd0;
      r_mwreg  <= 1'b0;
      r_mm2reg <= 1'b0;
      r_mwmem  <= 1'b0;
    end else if (w_adv) begin
      r_ern    <= w_bubble ? 5'd0 : hz.drn;
      r_ewreg  <= w_bubble ? 1'b0 : hz.dwreg;
      r_em2reg <= w_bubble ? 1'b0 : hz.dm2reg;
      r_ewmem  <= w_bubble ? 1'b0 : hz.dwmem;
      r_mrn    <= r_ern;
      r_mwreg  <= r_ewreg;
      r_mm2reg <= r_em2reg;
      r_mwmem  <= r_ewmem;
    end
  end

  // Memory wait FSM: request, wait for ack or timeout, retire one cycle
  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      r_state <= c_IDLE;
      r_cnt   <= 8'd0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        c_IDLE: begin
          if (w_memop) begin
            r_cnt   <= 8'd0;
            r_state <= c_WAIT;
          end
        end
        c_WAIT: begin
          r_cnt <= r_cnt + 8'd1;
          if (hz.mem_ack) begin
            r_state <= c_DONE;
          end else if (r_cnt == c_TIMEOUT) begin
            r_err   <= 1'b1;
            r_state <= c_DONE;
          end
        end
        c_DONE:  r_state <= c_IDLE;
        default: r_state <= c_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_pipe_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_pipe_hazard_ctrl
// Brief    : Self-checking bench for pipe_hazard_ctrl. Two instances (delay
//            slot / long timeout, and flush / short timeout) share one
//            stimulus stream; each is compared against a behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_pipe_hazard_ctrl;

  typedef struct packed {
    logic [4:0] rs, rt;
    logic       urs, urt;
    logic [4:0] rn;
    logic       wreg, m2reg, wmem, br, ack;
  } d_t;

  typedef struct packed {
    logic [4:0] rn;
    logic       wreg, m2reg, wmem;
  } ins_t;

  typedef struct packed {
    ins_t        e, m;
    logic        waiting, finishing, err;
    logic [31:0] elapsed;
  } mdl_t;

  typedef struct packed {
    logic [1:0] fa, fb;
    logic       wp, bub, adv, fl, req, err;
  } out_t;

  logic clk;
  logic clrn;
  d_t   din;
  int   n_checks;
  int   n_pass;

  pipe_hazard_if if0 ();
  pipe_hazard_if if1 ();

  assign if0.drs = din.rs;     assign if1.drs = din.rs;
  assign if0.drt = din.rt;     assign if1.drt = din.rt;
  assign if0.d_use_rs = din.urs; assign if1.d_use_rs = din.urs;
  assign if0.d_use_rt = din.urt; assign if1.d_use_rt = din.urt;
  assign if0.drn = din.rn;     assign if1.drn = din.rn;
  assign if0.dwreg = din.wreg; assign if1.dwreg = din.wreg;
  assign if0.dm2reg = din.m2reg; assign if1.dm2reg = din.m2reg;
  assign if0.dwmem = din.wmem; assign if1.dwmem = din.wmem;
  assign if0.d_branch_taken = din.br; assign if1.d_branch_taken = din.br;
  assign if0.mem_ack = din.ack; assign if1.mem_ack = din.ack;

  pipe_hazard_ctrl #(.DELAY_SLOT(1), .MEM_TIMEOUT(255)) dut0 (
    .clk(clk), .clrn(clrn), .hz(if0));
  pipe_hazard_ctrl #(.DELAY_SLOT(0), .MEM_TIMEOUT(3)) dut1 (
    .clk(clk), .clrn(clrn), .hz(if1));

  out_t act0, act1;
  assign act0 = {if0.fwda, if0.fwdb, if0.wpcir, if0.bubble, if0.adv,
                 if0.flush_fd, if0.mem_req, if0.mem_err};
  assign act1 = {if1.fwda, if1.fwdb, if1.wpcir, if1.bubble, if1.adv,
                 if1.flush_fd, if1.mem_req, if1.mem_err};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- model
  // Which stage can supply register r: youngest producer with data ready
  function automatic logic [1:0] src_of(input mdl_t s, input logic [4:0] r);
    if (r == 5'd0) return 2'd0;
    if (s.e.wreg && s.e.rn == r && !s.e.m2reg) return 2'd1;
    if (s.m.wreg && s.m.rn == r) return s.m.m2reg ? 2'd3 : 2'd2;
    return 2'd0;
  endfunction

  function automatic out_t mdl_out(input mdl_t s, input d_t d, input bit ds);
    out_t o;
    bit   memop, frz, hzd;
    memop = s.m.m2reg || s.m.wmem;
    frz   = s.waiting || (!s.finishing && memop);
    hzd   = s.e.wreg && s.e.m2reg && s.e.rn != 5'd0 &&
            ((d.urs && d.rs == s.e.rn) || (d.urt && d.rt == s.e.rn));
    o.fa  = src_of(s, d.rs);
    o.fb  = src_of(s, d.rt);
    o.req = frz;
    o.err = s.err;
    o.adv = !frz;
    o.wp  = !frz && !hzd;
    o.bub = !frz && hzd;
    o.fl  = !frz && !hzd && d.br && !ds;
    return o;
  endfunction

  function automatic mdl_t mdl_next(input mdl_t s, input d_t d, input bit ds, input int to);
    mdl_t n;
    out_t o;
    o = mdl_out(s, d, ds);
    n = s;
    if (s.waiting) begin
      if (d.ack || s.elapsed == 32'(to)) begin
        if (!d.ack) n.err = 1'b1;
        n.waiting   = 1'b0;
        n.finishing = 1'b1;
      end else begin
        n.elapsed = s.elapsed + 32'd1;
      end
    end else if (s.finishing) begin
      n.finishing = 1'b0;
    end else if (s.m.m2reg || s.m.wmem) begin
      n.waiting = 1'b1;
      n.elapsed = 32'd0;
    end
    if (o.adv) begin
      n.m = s.e;
      n.e = o.bub ? '0 : {d.rn, d.wreg, d.m2reg, d.wmem};
    end
    return n;
  endfunction

  mdl_t m0, m1;

  // Model state follows the clock and the asynchronous reset
  always @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      m0 <= '0;
      m1 <= '0;
    end else begin
      m0 <= mdl_next(m0, din, 1'b1, 255);
      m1 <= mdl_next(m1, din, 1'b0, 3);
    end
  end

  // ---------------------------------------------------------------- checks
  task automatic chk(input string nm, input int a, input int e);
    n_checks++;
    if (a == e) n_pass++;
    else $display("FAIL %s: got %0d expected %0d at %0t", nm, a, e, $time);
  endtask

  task automatic cmp_out(input string tag, input out_t a, input out_t e);
    chk({tag, ".fwda"},     int'(a.fa),  int'(e.fa));
    chk({tag, ".fwdb"},     int'(a.fb),  int'(e.fb));
    chk({tag, ".wpcir"},    int'(a.wp),  int'(e.wp));
    chk({tag, ".bubble"},   int'(a.bub), int'(e.bub));
    chk({tag, ".adv"},      int'(a.adv), int'(e.adv));
    chk({tag, ".flush_fd"}, int'(a.fl),  int'(e.fl));
    chk({tag, ".mem_req"},  int'(a.req), int'(e.req));
    chk({tag, ".mem_err"},  int'(a.err), int'(e.err));
  endtask

  // Every out-of-reset cycle both instances are compared against the model
  always @(negedge clk) begin
    if (clrn) begin
      cmp_out("mdl0", act0, mdl_out(m0, din, 1'b1));
      cmp_out("mdl1", act1, mdl_out(m1, din, 1'b0));
    end
  end

  // ---------------------------------------------------------------- stimulus
  task automatic setd(input logic [4:0] rs, input logic [4:0] rt,
                      input logic urs, input logic urt, input logic [4:0] rn,
                      input logic wreg, input logic m2reg, input logic wmem,
                      input logic br);
    din.rs = rs; din.rt = rt; din.urs = urs; din.urt = urt; din.rn = rn;
    din.wreg = wreg; din.m2reg = m2reg; din.wmem = wmem; din.br = br;
  endtask

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".req0"},  int'(if0.mem_req), 0);
    chk({tag, ".req1"},  int'(if1.mem_req), 0);
    chk({tag, ".err0"},  int'(if0.mem_err), 0);
    chk({tag, ".err1"},  int'(if1.mem_err), 0);
    chk({tag, ".adv"},   int'(if1.adv), 1);
    chk({tag, ".wpcir"}, int'(if1.wpcir), 1);
    chk({tag, ".bub"},   int'(if1.bubble), 0);
    chk({tag, ".fwda"},  int'(if0.fwda), 0);
    chk({tag, ".fl"},    int'(if1.flush_fd), 0);
  endtask

  initial begin
    n_checks = 0;
    n_pass   = 0;
    clrn     = 1'b0;
    din      = '0;
    #2;
    chk_reset("reset");
    repeat (2) @(posedge clk);
    #1 clrn = 1'b1;

    // ALU chain: add r3, then a reader of r3 one and two cycles behind
    setd(5'd1, 5'd2, 1, 1, 5'd3, 1, 0, 0, 0); nxt();
    setd(5'd3, 5'd5, 1, 1, 5'd4, 1, 0, 0, 0); @(negedge clk);
    chk("alu.fwda_e", int'(if0.fwda), 1);
    chk("alu.fwdb",   int'(if0.fwdb), 0);
    chk("alu.wpcir",  int'(if0.wpcir), 1);
    chk("alu.bubble", int'(if1.bubble), 0);
    nxt();
    setd(5'd3, 5'd0, 1, 0, 5'd6, 1, 0, 0, 0); @(negedge clk);
    chk("alu.fwda_m", int'(if1.fwda), 2);
    nxt();

    // Load-use: lw r2 then consumer of r2 with a taken branch
    setd(5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0, 0); nxt();
    setd(5'd2, 5'd0, 1, 0, 5'd7, 1, 0, 0, 1); @(negedge clk);
    chk("lu.wpcir",  int'(if0.wpcir), 0);
    chk("lu.bubble", int'(if0.bubble), 1);
    chk("lu.adv",    int'(if0.adv), 1);
    chk("lu.flush",  int'(if1.flush_fd), 0);
    nxt();
    // The load now sits in M: forwarding from memory data, pipeline frozen
    @(negedge clk);
    chk("lu.fwda_mem",  int'(if0.fwda), 3);
    chk("lu.bub_once",  int'(if0.bubble), 0);
    chk("slow.req_idle", int'(if0.mem_req), 1);
    chk("slow.adv_idle", int'(if1.adv), 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      if (i == 3) din.ack = 1'b1;
      @(negedge clk);
      chk("slow.req_wait", int'(if0.mem_req), 1);
      chk("slow.adv_wait", int'(if1.adv), 0);
      nxt();
    end
    din.ack = 1'b0;
    @(negedge clk);
    chk("slow.req_done", int'(if0.mem_req), 0);
    chk("slow.adv_done", int'(if0.adv), 1);
    chk("slow.err",      int'(if1.mem_err), 0);
    chk("br.flush_late", int'(if1.flush_fd), 1);
    chk("br.delay_slot", int'(if0.flush_fd), 0);
    nxt();

    // Load into r0 followed by readers of r0
    setd(5'd0, 5'd0, 0, 0, 5'd0, 1, 1, 0, 0); nxt();
    setd(5'd0, 5'd0, 1, 1, 5'd8, 1, 0, 0, 0); @(negedge clk);
    chk("r0.wpcir", int'(if1.wpcir), 1);
    chk("r0.bubble", int'(if1.bubble), 0);
    chk("r0.fwda",  int'(if1.fwda), 0);
    chk("r0.fwdb",  int'(if0.fwdb), 0);
    nxt();
    setd(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0); @(negedge clk);
    chk("r0ld.req_idle", int'(if0.mem_req), 1);
    nxt();
    din.ack = 1'b1; @(negedge clk);
    chk("r0ld.req_wait", int'(if0.mem_req), 1);
    nxt();
    din.ack = 1'b0; @(negedge clk);
    chk("r0ld.req_done", int'(if1.mem_req), 0);
    nxt();

    // Store with no ack: short-timeout instance gives up after 4 WAIT cycles
    setd(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 1, 0); nxt();
    setd(5'd0, 5'd0, 0, 0, 5'd0, 0, 0, 0, 0); nxt();
    @(negedge clk);
    chk("to.req_idle", int'(if1.mem_req), 1);
    chk("to.adv_idle", int'(if1.adv), 0);
    nxt();
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      chk("to.req_wait", int'(if1.mem_req), 1);
      nxt();
    end
    @(negedge clk);
    chk("to.req_drop",   int'(if1.mem_req), 0);
    chk("to.err",        int'(if1.mem_err), 1);
    chk("to.long_wait",  int'(if0.mem_req), 1);
    chk("to.long_err",   int'(if0.mem_err), 0);
    nxt();
    @(negedge clk);
    chk("to.sticky",     int'(if1.mem_err), 1);
    chk("rst.pre_req",   int'(if0.mem_req), 1);
    #2 clrn = 1'b0;
    #1 chk_reset("rst_wait");
    @(posedge clk);
    #1 clrn = 1'b1;

    // Randomised traffic with occasional asynchronous resets
    for (int cyc = 0; cyc < 3000; cyc++) begin
      int kind;
      din.rs  = 5'($urandom_range(0, 3));
      din.rt  = 5'($urandom_range(0, 3));
      din.urs = 1'($urandom_range(0, 1));
      din.urt = 1'($urandom_range(0, 1));
      din.rn  = 5'($urandom_range(0, 3));
      kind    = int'($urandom_range(0, 9));
      din.m2reg = (kind == 0);
      din.wmem  = (kind == 1);
      din.wreg  = (kind == 0) || (kind > 1 && $urandom_range(0, 3) != 0);
      din.br    = ($urandom_range(0, 5) == 0);
      din.ack   = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 299) == 0) begin
        din = '0;
        #1 clrn = 1'b0;
        #1 chk_reset("rst_rand");
        @(posedge clk);
        #1 clrn = 1'b1;
      end else begin
        nxt();
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Hazard and sequencing controller for the 5-stage pipeline. Sits beside the ID/EX, EX/MEM and MEM/WB pipeline registers.
- Shadows the destination and write-back controls of instructions in E and M. Generates operand-forwarding selects, load-use stall/bubble, IF/ID write enable and branch flush.
- Runs a memory-wait state machine that freezes the whole pipeline while a slow data memory completes an M-stage load/store.

Parameters:
- DELAY_SLOT, 1, 1 = branch delay slot architected (flush_fd never asserted); 0 = flush IF/ID on taken branch.
- MEM_TIMEOUT, 255, max WAIT cycles before forced completion; 8-bit counter.

Ports:
- clk  input  1  clock, rising edge
- clrn  input  1  asynchronous active-low reset
- drs  input  5  D-stage rs field
- drt  input  5  D-stage rt field
- d_use_rs  input  1  D instruction reads rs
- d_use_rt  input  1  D instruction reads rt
- drn  input  5  D-stage destination register
- dwreg  input  1  D instruction writes register file
- dm2reg  input  1  D instruction is a load
- dwmem  input  1  D instruction is a store
- d_branch_taken  input  1  branch/jump resolved taken in D
- mem_ack  input  1  data memory completion, single-cycle pulse
- fwda  output  2  rs operand select: 0 regfile, 1 E ALU result, 2 M ALU result, 3 M memory data
- fwdb  output  2  rt operand select, same encoding as fwda
- wpcir  output  1  PC and IF/ID write enable
- bubble  output  1  ID/EX loads NOP controls (wreg/m2reg/wmem = 0)
- adv  output  1  ID/EX, EX/MEM, MEM/WB advance enable
- flush_fd  output  1  clear IF/ID
- mem_req  output  1  data memory request, held until ack
- mem_err  output  1  sticky memory timeout flag

Behaviour:
Internal shadow registers:
- ern, ewreg, em2reg, ewmem, mrn, mwreg, mm2reg, mwmem.
- When adv=1: E shadow <= D inputs (forced to 0 if bubble=1); M shadow <= E shadow.
- When adv=0: all shadow registers hold.

Forwarding (combinational):
- fwda = 1 if ewreg && ern!=0 && ern==drs && !em2reg.
- Else fwda = 3 if mwreg && mm2reg && mrn!=0 && mrn==drs.
- Else fwda = 2 if mwreg && mrn!=0 && mrn==drs.
- Else fwda = 0.
- fwdb: same rules on drt. Forwarding is computed regardless of d_use_*.

Load-use stall:
- stall = ewreg && em2reg && ern!=0 && ((d_use_rs && ern==drs) || (d_use_rt && ern==drt)).

Memory FSM (states IDLE, WAIT, DONE; 8-bit counter cnt):
- IDLE: if mm2reg||mwmem, mem_req=1, cnt<=0, go WAIT; else stay.
- WAIT: mem_req=1, cnt++.
  - On mem_ack: go DONE.
  - Else if cnt==MEM_TIMEOUT: mem_err<=1, go DONE.
- DONE: mem_req=0, go IDLE. The M instruction retires this cycle; the next M op is seen in IDLE on the following cycle.
- mem_ack outside WAIT is ignored.
- freeze = (IDLE && (mm2reg||mwmem)) || WAIT.

Output priority:
- freeze: adv=0, wpcir=0, bubble=0, flush_fd=0.
- Else stall: adv=1, wpcir=0, bubble=1, flush_fd=0.
- Else: adv=1, wpcir=1, bubble=0, flush_fd = d_branch_taken && !DELAY_SLOT.

Reset:
- All shadow registers 0, state IDLE, cnt 0, mem_err 0.
- Resulting outputs: fwda=fwdb=0, wpcir=1, bubble=0, adv=1, flush_fd=0, mem_req=0.
- Reset during WAIT abandons the request; mem_req drops immediately.

Boundary conditions:
- Register 0 is never forwarded and never stalls.
- If E and M both match, E wins.
- A load in E plus a consumer in D plus a freeze: freeze dominates, and the stall is re-evaluated after the freeze ends.
- A taken branch during a stall is not flushed until the stall clears.
- Back-to-back memory ops each get an independent request.

Test Plan:
- ALU chain: add r3 then sub r4,r3,r5 in D -> fwda=1, no stall; one cycle later (r3 in M, non-load) -> fwda=2.
- Load-use: lw r2 in E, D reads rs=r2 with d_use_rs=1 -> wpcir=0, bubble=1, adv=1 for exactly 1 cycle; next cycle fwda=3.
- Write to r0: lw r0 in E, D reads rs=0 -> no stall, fwda=0.
- Slow memory: sw reaches M, mem_ack after 4 cycles -> mem_req=1 and adv=0 for 5 cycles, DONE cycle adv=1, mem_err=0.
- Timeout with MEM_TIMEOUT=3 and no ack -> mem_req deasserts after 4 WAIT cycles, mem_err=1 and stays 1 until clrn.
- DELAY_SLOT=0, taken branch, no hazard -> flush_fd=1 for one cycle; with load-use present at the same time -> flush_fd=0 and bubble=1; assert clrn=0 in WAIT -> mem_req=0 asynchronously.
